// File: rtl/angle_wrap_sequencer.sv
// angle_wrap_sequencer: walks an angle memory and folds each IEEE-754 single
// entry into [-pi, pi]. Out-of-range values get +/-2pi added repeatedly
// through a shared external FP adder. Each result is written back to the
// entry it came from.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start_angle_wrap        one-cycle run request (accepted only when idle)
//   mem_angle_read_addr     read address; data is returned one cycle later
//   mem_angle_data_out      read data
//   mem_angle_write_*       write-back port (addr, data, enable)
//   add_operand_a/b         adder operands, held from request to result
//   add_start               one-cycle adder request
//   add_result(_ready)      adder sum and its valid strobe
//   angle_wrap_done         one-cycle completion pulse
//   angle_wrap_error        sticky per run: non-finite input or iteration cap
//
// Build option
//   ANGLE_WRAP_ITER_LIMIT_EN  when defined, an entry still out of range after
//                             MAX_ITER adds is written as-is and flags error.
module angle_wrap_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_ANGLE  = 21,
  parameter int unsigned MAX_ITER   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_angle_wrap,
  output logic [$clog2(NUM_ANGLE)-1:0] mem_angle_read_addr,
  input  logic [DATA_WIDTH-1:0]        mem_angle_data_out,
  output logic [$clog2(NUM_ANGLE)-1:0] mem_angle_write_addr,
  output logic [DATA_WIDTH-1:0]        mem_angle_data_in,
  output logic                         mem_angle_write_en,
  output logic [DATA_WIDTH-1:0]        add_operand_a,
  output logic [DATA_WIDTH-1:0]        add_operand_b,
  output logic                         add_start,
  input  logic [DATA_WIDTH-1:0]        add_result,
  input  logic                         add_result_ready,
  output logic                         angle_wrap_done,
  output logic                         angle_wrap_error
);

  localparam int unsigned IDX_W  = $clog2(NUM_ANGLE);
  localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
  localparam int unsigned SIGN_B = DATA_WIDTH - 1;

  localparam logic [DATA_WIDTH-2:0] PI_MAG     = (DATA_WIDTH-1)'(32'h40490FDB);
  localparam logic [DATA_WIDTH-1:0] TWO_PI     = DATA_WIDTH'(32'h40C90FDB);
  localparam logic [DATA_WIDTH-1:0] NEG_TWO_PI = DATA_WIDTH'(32'hC0C90FDB);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_ANGLE - 1);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, CHECK, ADD_REQ, ADD_WAIT, WRITE, DONE
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        index;
  logic [DATA_WIDTH-1:0]   w;
  logic [ITER_W-1:0]       iter_cnt;

  // Classification of the working value.
  logic non_finite;
  logic out_of_range;
  logic iter_limit_hit;

  // Exponent all ones means Inf or NaN.
  assign non_finite   = &w[SIGN_B-1:23];
  // Sign-magnitude compare: |w| > |pi| is out of range for either sign.
  assign out_of_range = !non_finite && (w[SIGN_B-1:0] > PI_MAG);

`ifdef ANGLE_WRAP_ITER_LIMIT_EN
  assign iter_limit_hit = (iter_cnt == ITER_W'(MAX_ITER));
`else
  assign iter_limit_hit = 1'b0;
`endif

  // Sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      index                <= '0;
      w                    <= '0;
      iter_cnt             <= '0;
      mem_angle_read_addr  <= '0;
      mem_angle_write_addr <= '0;
      mem_angle_data_in    <= '0;
      mem_angle_write_en   <= 1'b0;
      add_operand_a        <= '0;
      add_operand_b        <= '0;
      add_start            <= 1'b0;
      angle_wrap_done      <= 1'b0;
      angle_wrap_error     <= 1'b0;
    end else begin
      add_start          <= 1'b0;
      mem_angle_write_en <= 1'b0;
      angle_wrap_done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start_angle_wrap) begin
            index               <= '0;
            mem_angle_read_addr <= '0;
            angle_wrap_error    <= 1'b0;
            state               <= READ;
          end
        end

        // Address is already on mem_angle_read_addr; data arrives next cycle.
        READ: state <= CAPTURE;

        CAPTURE: begin
          w        <= mem_angle_data_out;
          iter_cnt <= '0;
          state    <= CHECK;
        end

        CHECK: begin
          if (out_of_range && !iter_limit_hit) begin
            add_start     <= 1'b1;
            add_operand_a <= w;
            add_operand_b <= w[SIGN_B] ? TWO_PI : NEG_TWO_PI;
            state         <= ADD_REQ;
          end else begin
            // Reaching here while out of range means the iteration cap hit.
            if (non_finite || out_of_range) angle_wrap_error <= 1'b1;
            mem_angle_write_en   <= 1'b1;
            mem_angle_write_addr <= index;
            mem_angle_data_in    <= w;
            state                <= WRITE;
          end
        end

        ADD_REQ: begin
          iter_cnt <= iter_cnt + ITER_W'(1);
          state    <= ADD_WAIT;
        end

        ADD_WAIT: begin
          if (add_result_ready) begin
            w             <= add_result;
            add_operand_a <= '0;
            add_operand_b <= '0;
            state         <= CHECK;
          end
        end

        WRITE: begin
          if (index == LAST_IDX) begin
            angle_wrap_done <= 1'b1;
            state           <= DONE;
          end else begin
            index               <= index + IDX_W'(1);
            mem_angle_read_addr <= index + IDX_W'(1);
            state               <= READ;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_wrap_sequencer.sv
// Self-checking bench for angle_wrap_sequencer: directed table, latency,
// reset-during-add abort, and randomized runs against a real-arithmetic model.
module tb_angle_wrap_sequencer;

  localparam int DW       = 32;
  localparam int N        = 21;
  localparam int MAX_ITER = 8;
  localparam int AW       = $clog2(N);
`ifdef ANGLE_WRAP_ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [31:0] PI_BITS = 32'h40490FDB;
  localparam logic [31:0] P2PI    = 32'h40C90FDB;
  localparam logic [31:0] M2PI    = 32'hC0C90FDB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [DW-1:0] op_a, op_b;
  logic          add_start;
  logic [DW-1:0] add_result = '0;
  logic          add_ready  = 1'b0;
  logic          done, error;

  angle_wrap_sequencer #(.DATA_WIDTH(DW), .NUM_ANGLE(N), .MAX_ITER(MAX_ITER)) dut (
    .clock               (clock),
    .reset               (reset),
    .start_angle_wrap    (start),
    .mem_angle_read_addr (rd_addr),
    .mem_angle_data_out  (rd_data),
    .mem_angle_write_addr(wr_addr),
    .mem_angle_data_in   (wr_data),
    .mem_angle_write_en  (wr_en),
    .add_operand_a       (op_a),
    .add_operand_b       (op_b),
    .add_start           (add_start),
    .add_result          (add_result),
    .add_result_ready    (add_ready),
    .angle_wrap_done     (done),
    .angle_wrap_error    (error)
  );

  always #5 clock = ~clock;

  // ---------------- single-precision helpers (normal numbers) ----------------
  function automatic real sp_to_real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]} + 25'(d[28] && ((|d[27:0]) || d[29]));
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_sp(sp_to_real(a) + sp_to_real(b));
  endfunction

  // ---------------- memory and adder models ----------------
  logic [31:0] mem [N];
  always @(posedge clock) rd_data <= mem[rd_addr];

  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_sum = '0;
  always @(posedge clock) begin
    add_ready <= 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        add_ready  <= 1'b1;
        add_result <= pend_sum;
        pend       <= 1'b0;
      end else pend_cnt <= pend_cnt - 1;
    end
    if (add_start) begin
      pend     <= 1'b1;
      pend_cnt <= int'($urandom_range(0, 2));
      pend_sum <= fp_add(op_a, op_b);
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            adds;
  } wr_t;

  wr_t         wr_q[$];
  logic [63:0] add_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;
  int          start_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    wr_t e;
    if (wr_en) begin
      e.addr = wr_addr;
      e.data = wr_data;
      e.adds = add_q.size();
      wr_q.push_back(e);
    end
    if (add_start) add_q.push_back({op_a, op_b});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_near(input string nm, input logic [31:0] act, input real exp);
    real a, d;
    n_chk = n_chk + 1;
    a = sp_to_real(act);
    d = (a > exp) ? a - exp : exp - a;
    if (act[30:23] != 8'hFF && d < 1.0e-4) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h (%f) expected ~%f", nm, act, a, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_wr[$];
  int          exp_adds[$];
  logic [63:0] exp_add_q[$];
  bit          exp_err;

  task automatic model_run();
    real         pi_r, x;
    logic [31:0] v, b;
    int          n;
    bit          fin;
    exp_wr.delete();
    exp_adds.delete();
    exp_add_q.delete();
    exp_err = 1'b0;
    pi_r = sp_to_real(PI_BITS);
    for (int k = 0; k < N; k++) begin
      v   = mem[k];
      n   = 0;
      fin = 1'b0;
      if (v[30:23] == 8'hFF) begin
        exp_err = 1'b1;
        fin     = 1'b1;
      end
      while (!fin) begin
        x = sp_to_real(v);
        if (x >= -pi_r && x <= pi_r) fin = 1'b1;
        else if (LIMIT_EN && n == MAX_ITER) begin
          exp_err = 1'b1;
          fin     = 1'b1;
        end else begin
          b = (x > 0.0) ? M2PI : P2PI;
          exp_add_q.push_back({v, b});
          v = fp_add(v, b);
          n = n + 1;
        end
      end
      exp_wr.push_back(v);
      exp_adds.push_back(n);
    end
  endtask

  task automatic run(input bit spam);
    wr_q.delete();
    add_q.delete();
    done_cnt = 0;
    @(negedge clock);
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      @(posedge clock);
      #1;
      if (spam) start = (i == 12 || i == 30);
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("done_once", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_run(input string tag);
    int prev;
    chk({tag, " writes"}, 32'(wr_q.size()), 32'(N));
    prev = 0;
    for (int k = 0; k < N && k < wr_q.size(); k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), 32'(wr_q[k].addr), 32'(k));
      chk($sformatf("%s data[%0d]", tag, k), wr_q[k].data, exp_wr[k]);
      chk($sformatf("%s adds[%0d]", tag, k), 32'(wr_q[k].adds - prev), 32'(exp_adds[k]));
      prev = wr_q[k].adds;
    end
    chk({tag, " add_total"}, 32'(add_q.size()), 32'(exp_add_q.size()));
    for (int j = 0; j < add_q.size() && j < exp_add_q.size(); j++) begin
      chk($sformatf("%s op_a[%0d]", tag, j), add_q[j][63:32], exp_add_q[j][63:32]);
      chk($sformatf("%s op_b[%0d]", tag, j), add_q[j][31:0], exp_add_q[j][31:0]);
    end
    chk({tag, " error"}, 32'(error), 32'(exp_err));
    chk({tag, " idle_op_a"}, op_a, 32'd0);
    chk({tag, " idle_op_b"}, op_b, 32'd0);
  endtask

  function automatic logic [31:0] rand_angle();
    int unsigned s;
    s = $urandom_range(0, 19);
    case (s)
      0:       return 32'h7FC00000;
      1:       return 32'hFF800000;
      2:       return PI_BITS;
      3:       return 32'hC0490FDB;
      4:       return 32'h40490FDC;
      5:       return 32'hC0490FDC;
      default: return real_to_sp((real'($urandom_range(0, 40000)) - 20000.0) / 250.0);
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] in;
    bit          exact;
    logic [31:0] bits;
    real         val;
    int          adds;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int seen;
    bit got;
    int prev;

    tbl[0]  = '{32'h3F800000, 1'b1, 32'h3F800000,  0.0,      0};
    tbl[1]  = '{32'h40800000, 1'b0, 32'h0,        -2.28319,  1};
    tbl[2]  = '{32'hC0E00000, 1'b0, 32'h0,        -0.71681,  1};
    tbl[3]  = '{32'h40490FDB, 1'b1, 32'h40490FDB,  0.0,      0};
    tbl[4]  = '{32'h41200000, 1'b0, 32'h0,        -2.56637,  2};
    tbl[5]  = '{32'hC0490FDB, 1'b1, 32'hC0490FDB,  0.0,      0};
    tbl[6]  = '{32'h80000000, 1'b1, 32'h80000000,  0.0,      0};
    tbl[7]  = '{32'h00000000, 1'b1, 32'h00000000,  0.0,      0};
    tbl[8]  = '{32'h7FC00000, 1'b1, 32'h7FC00000,  0.0,      0};
    tbl[9]  = '{32'hFF800000, 1'b1, 32'hFF800000,  0.0,      0};
    tbl[10] = '{32'h40490FDC, 1'b0, 32'h0,        -3.14159,  1};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst add_start", 32'(add_start), 32'd0);
    chk("rst op_a", op_a, 32'd0);
    chk("rst op_b", op_b, 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;

    // Directed table run
    for (int k = 0; k < N; k++) mem[k] = (k < 11) ? tbl[k].in : 32'h3F800000;
    model_run();
    run(1'b0);
    check_run("dir");
    prev = 0;
    for (int k = 0; k < 11 && k < wr_q.size(); k++) begin
      chk($sformatf("tbl adds[%0d]", k), 32'(wr_q[k].adds - prev), 32'(tbl[k].adds));
      prev = wr_q[k].adds;
      if (tbl[k].exact) chk($sformatf("tbl data[%0d]", k), wr_q[k].data, tbl[k].bits);
      else chk_near($sformatf("tbl data[%0d]", k), wr_q[k].data, tbl[k].val);
    end
    chk("tbl error", 32'(error), 32'd1);

    // All in range: minimum latency of 4 cycles per entry, no adds
    for (int k = 0; k < N; k++)
      mem[k] = real_to_sp((real'($urandom_range(0, 6000)) - 3000.0) / 1000.0);
    model_run();
    run(1'b0);
    check_run("lat");
    chk("lat cycles", 32'(done_cyc - start_cyc), 32'(4 * N));
    chk("lat error_cleared", 32'(error), 32'd0);

    // Reset while waiting on the adder: abort, no write, no done
    for (int k = 0; k < N; k++) mem[k] = 32'h3F800000;
    mem[0] = 32'h49742400;
    wr_q.delete();
    add_q.delete();
    done_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    got  = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clock);
      if (add_start) begin
        seen = seen + 1;
        if (seen == 3) got = 1'b1;
      end
    end
    chk("abort reached_add", 32'(got), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort wr_en", 32'(wr_en), 32'd0);
    chk("abort add_start", 32'(add_start), 32'd0);
    chk("abort op_a", op_a, 32'd0);
    chk("abort op_b", op_b, 32'd0);
    chk("abort rd_addr", 32'(rd_addr), 32'd0);
    repeat (8) @(negedge clock);
    chk("abort no_write", 32'(wr_q.size()), 32'd0);
    chk("abort no_done", 32'(done_cnt), 32'd0);
    chk("abort no_more_adds", 32'(add_q.size()), 32'd3);

`ifdef ANGLE_WRAP_ITER_LIMIT_EN
    // Iteration cap: 1e6 stops after MAX_ITER adds and flags error
    model_run();
    run(1'b0);
    check_run("limit");
    if (wr_q.size() > 0) chk("limit adds[0]", 32'(wr_q[0].adds), 32'(MAX_ITER));
    chk("limit error", 32'(error), 32'd1);
`endif

    // Randomized runs; the first also fires start mid-run, which must be ignored
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) mem[k] = rand_angle();
      model_run();
      run(r == 0);
      check_run($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/angle_wrap_sequencer.md
ANGLE_WRAP_SEQUENCER -- requirements
Module: angle_wrap_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, IEEE-754 single word width; NUM_ANGLE, default 21, angle entries processed per run; MAX_ITER, default 8, add iterations allowed per entry.
REQ-002 clock  input  1  sole clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start_angle_wrap  input  1  single-cycle run request.
REQ-005 mem_angle_read_addr  output  $clog2(NUM_ANGLE)  angle memory read address; data is valid the cycle after the address is presented.
REQ-006 mem_angle_data_out  input  DATA_WIDTH  angle memory read data.
REQ-007 mem_angle_write_addr, mem_angle_data_in, mem_angle_write_en  output  $clog2(NUM_ANGLE)/DATA_WIDTH/1  write-back port.
REQ-008 add_operand_a, add_operand_b  output  DATA_WIDTH  shared FP adder operands.
REQ-009 add_start  output  1  adder request pulse.
REQ-010 add_result, add_result_ready  input  DATA_WIDTH/1  adder sum and its valid strobe.
REQ-011 angle_wrap_done  output  1  one-cycle completion pulse.
REQ-012 angle_wrap_error  output  1  sticky per run; set on non-finite input or iteration overflow.

Function
REQ-013 FSM states SHALL be IDLE, READ, CAPTURE, CHECK, ADD_REQ, ADD_WAIT, WRITE, DONE.
REQ-014 IDLE: on start_angle_wrap=1, SHALL clear index and error, then go to READ; start is ignored in every other state.
REQ-015 READ: SHALL drive mem_angle_read_addr=index -> CAPTURE; CAPTURE latches mem_angle_data_out into the working register, clears the iteration count -> CHECK.
REQ-016 CHECK: working value w is in range iff -pi <= w <= pi (pi = 0x40490FDB); comparison uses the sign bit plus an unsigned compare of bits[30:0]; +0/-0 are in range; exactly +/-pi is in range.
REQ-017 CHECK: in range -> WRITE; w > pi -> ADD_REQ with operand_b = -2pi (0xC0C90FDB); w < -pi -> ADD_REQ with operand_b = +2pi (0x40C90FDB).
REQ-018 CHECK: exponent all ones (Inf/NaN) -> set error, -> WRITE with the value unchanged.
REQ-019 ADD_REQ: SHALL assert add_start for exactly one cycle with operand_a=w; operands are held stable through ADD_WAIT; iteration count increments.
REQ-020 ADD_WAIT: on add_result_ready=1, SHALL latch add_result into w -> CHECK; otherwise wait indefinitely.
REQ-021 WRITE: SHALL assert mem_angle_write_en for one cycle with write_addr=index and data_in=w; index==NUM_ANGLE-1 -> DONE, else index+1 -> READ.
REQ-022 DONE: SHALL pulse angle_wrap_done for one cycle -> IDLE; error holds until the next accepted start.
REQ-023 Outside ADD_REQ/ADD_WAIT, add operands SHALL be 0; outside WRITE, write_en SHALL be 0.
REQ-024 Minimum per-entry latency: 4 cycles with no adds; each add adds 2 cycles plus adder latency.

Reset
REQ-025 Reset SHALL force IDLE, zero index, working register, iteration count, and all outputs, including error and done.
REQ-026 Reset mid-run SHALL abort without a write in the cycle of reset and without asserting done; an outstanding adder ready is ignored afterwards.

Configuration
REQ-027 Macro ANGLE_WRAP_ITER_LIMIT_EN defined: in CHECK, an out-of-range value with iteration count == MAX_ITER SHALL set error and go to WRITE with the current w.
REQ-028 Macro undefined: no iteration limit; error is set only by non-finite inputs.

Verification
REQ-029 Entry 0x3F800000 (1.0) -> no add_start; written back 0x3F800000.
REQ-030 Entry 0x40800000 (4.0) -> one add with b=0xC0C90FDB; written back approx -2.28319; entry 0xC0E00000 (-7.0) -> one add with b=0x40C90FDB, approx -0.71681.
REQ-031 Entries 0x40490FDB (pi) and 0x41200000 (10.0) -> pi is written with no add; 10.0 takes two adds and is written as approx -2.56637.
REQ-032 Entry 0x7FC00000 (NaN) -> written unchanged, error=1, done pulses after NUM_ANGLE writes.
REQ-033 Entry 0x49742400 (1e6) with the macro defined and MAX_ITER=8 -> 8 adds, error=1; reset asserted in ADD_WAIT -> IDLE next cycle, no write, no done.
